// File: rtl/csla_pkg.sv
// Shared configuration helpers for the pipelined carry-select adder.
package csla_pkg;

    localparam int CSLA_WIDTH_DEF  = 64;
    localparam int CSLA_SEG_W_DEF  = 8;
    localparam int CSLA_STAGES_DEF = 2;

    function automatic int csla_segs(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    // Segments handled by each pipeline slice in the default build.
    localparam int SEGS_PER_STAGE = csla_segs(CSLA_WIDTH_DEF, CSLA_SEG_W_DEF) / CSLA_STAGES_DEF;

    function automatic bit csla_cfg_ok(input int width, input int seg_w, input int stages);
        if (seg_w < 1 || stages < 1 || width < seg_w) begin
            return 1'b0;
        end
        return ((width % seg_w) == 0) && (((width / seg_w) % stages) == 0);
    endfunction

endpackage

// File: rtl/csla_segment.sv
// One carry-select segment: two ripple adders (carry-in 0 and 1) and a 2:1 select.
module csla_segment
    import csla_pkg::*;
#(
    parameter int SEG_W = CSLA_SEG_W_DEF
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             sel_cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);

    logic [SEG_W:0] sum0;
    logic [SEG_W:0] sum1;

    assign sum0 = {1'b0, a} + {1'b0, b};
    assign sum1 = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, 1'b1};

    assign {cout, sum} = sel_cin ? sum1 : sum0;

endmodule

// File: rtl/csla_pipe_adder.sv
// Pipelined carry-select adder/subtractor with a whole-pipe valid/ready stall.
// Define CSLA_PIPE_OVF_EN to add the registered signed-overflow output out_ovf.
module csla_pipe_adder
    import csla_pkg::*;
#(
    parameter int WIDTH  = CSLA_WIDTH_DEF,
    parameter int SEG_W  = CSLA_SEG_W_DEF,
    parameter int STAGES = CSLA_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CSLA_PIPE_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int SEGS    = csla_segs(WIDTH, SEG_W);
    localparam int SPS     = SEGS / STAGES;
    localparam int SLICE_W = SPS * SEG_W;

    if (!csla_cfg_ok(WIDTH, SEG_W, STAGES)) begin : g_bad_cfg
        $error("csla_pipe_adder: WIDTH, SEG_W and STAGES do not divide evenly");
    end

    typedef struct packed {
        logic             valid;
        logic             carry;
`ifdef CSLA_PIPE_OVF_EN
        logic             ovf;
`endif
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t in_s;
    stage_t src_s   [STAGES];
    stage_t stage_q [STAGES];
    logic   advance;

    // Operand conditioning: subtraction becomes A + ~B + 1 before slice 0.
    always_comb begin
        in_s       = '0;
        in_s.valid = in_valid;
        in_s.carry = in_sub | in_cin;
        in_s.a     = in_a;
        in_s.b     = in_sub ? ~in_b : in_b;
    end

    assign advance  = !stage_q[STAGES-1].valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SLICE_W-1:0] slice_sum;
        logic               slice_cout;
        stage_t             stg_d;
        stage_t             stg_q;

        if (k == 0) begin : g_src_in
            assign src_s[k] = in_s;
        end else begin : g_src_reg
            assign src_s[k] = stage_q[k-1];
        end

        for (genvar j = 0; j < SPS; j++) begin : g_seg
            localparam int LSB = (k * SPS + j) * SEG_W;
            logic ci;
            logic co;

            if (j == 0) begin : g_ci_slice
                assign ci = src_s[k].carry;
            end else begin : g_ci_chain
                assign ci = g_seg[j-1].co;
            end

            csla_segment #(
                .SEG_W(SEG_W)
            ) u_seg (
                .a      (src_s[k].a[LSB +: SEG_W]),
                .b      (src_s[k].b[LSB +: SEG_W]),
                .sel_cin(ci),
                .sum    (slice_sum[j*SEG_W +: SEG_W]),
                .cout   (co)
            );
        end

        assign slice_cout = g_seg[SPS-1].co;

        always_comb begin
            stg_d                            = src_s[k];
            stg_d.sum[k*SLICE_W +: SLICE_W]  = slice_sum;
            stg_d.carry                      = slice_cout;
`ifdef CSLA_PIPE_OVF_EN
            // Carry into the MSB is recovered from the MSB sum bit of the last slice.
            if (k == STAGES - 1) begin
                stg_d.ovf = slice_cout ^ src_s[k].a[WIDTH-1] ^ src_s[k].b[WIDTH-1]
                            ^ slice_sum[SLICE_W-1];
            end
`endif
        end

        // Stage k register boundary; the whole pipe freezes when advance is low.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stg_q <= '0;
            end else if (advance) begin
                stg_q <= stg_d;
            end
        end

        assign stage_q[k] = stg_q;
    end

    assign out_valid = stage_q[STAGES-1].valid;
    assign out_sum   = stage_q[STAGES-1].sum;
    assign out_cout  = stage_q[STAGES-1].carry;
`ifdef CSLA_PIPE_OVF_EN
    assign out_ovf   = stage_q[STAGES-1].ovf;
`endif

endmodule

// File: tb/tb_csla_pipe_adder.sv
// Directed self-checking bench for csla_pipe_adder (default WIDTH=64, SEG_W=8, STAGES=2).
module tb_csla_pipe_adder;

    localparam int W = 64;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         in_cin    = 1'b0;
    logic         in_sub    = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef CSLA_PIPE_OVF_EN
    logic         out_ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csla_pipe_adder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
`ifdef CSLA_PIPE_OVF_EN
        ,
        .out_ovf  (out_ovf)
`endif
    );

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        if (sub) begin
            return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        end
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        in_b     = 64'd1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_sum !== 64'd0) begin errors++; $display("FAIL reset_sum: got %h expected 0", out_sum); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", out_cout); end
`ifdef CSLA_PIPE_OVF_EN
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", out_ovf); end
`endif
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_add();
        logic [W-1:0] ta [5];
        logic [W-1:0] tb [5];
        logic         tc [5];
        logic [W-1:0] es [5];
        logic         ec [5];
        logic         eo [5];
        ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb[0] = 64'd1;                 tc[0] = 1'b0;
        es[0] = 64'h0;                   ec[0] = 1'b1;                  eo[0] = 1'b0;
        ta[1] = 64'h0000_0000_FFFF_FFFF; tb[1] = 64'd1;                 tc[1] = 1'b0;
        es[1] = 64'h0000_0001_0000_0000; ec[1] = 1'b0;                  eo[1] = 1'b0;
        ta[2] = 64'h0000_0000_0000_00FF; tb[2] = 64'd0;                 tc[2] = 1'b1;
        es[2] = 64'h0000_0000_0000_0100; ec[2] = 1'b0;                  eo[2] = 1'b0;
        ta[3] = 64'h1234_5678_9ABC_DEF0; tb[3] = 64'h1111_1111_1111_1111; tc[3] = 1'b1;
        es[3] = 64'h2345_6789_ABCD_F002; ec[3] = 1'b0;                  eo[3] = 1'b0;
        ta[4] = 64'h8000_0000_0000_0000; tb[4] = 64'h8000_0000_0000_0000; tc[4] = 1'b0;
        es[4] = 64'h0;                   ec[4] = 1'b1;                  eo[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(ta[i], tb[i], tc[i], 1'b0);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency[%0d]: out_valid %b after 1 cycle, expected 0", i, out_valid); end
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_sum !== es[i]) begin errors++; $display("FAIL add_sum[%0d]: got %h expected %h", i, out_sum, es[i]); end
            checks++; if (out_cout !== ec[i]) begin errors++; $display("FAIL add_cout[%0d]: got %b expected %b", i, out_cout, ec[i]); end
`ifdef CSLA_PIPE_OVF_EN
            checks++; if (out_ovf !== eo[i]) begin errors++; $display("FAIL add_ovf[%0d]: got %b expected %b", i, out_ovf, eo[i]); end
`else
            if (eo[i] === 1'bx) $display("note: unexpected table entry");
`endif
        end
    endtask

    task automatic test_subtract();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic [W-1:0] es [4];
        logic         ec [4];
        logic         eo [4];
        ta[0] = 64'd5;                   tb[0] = 64'd7;
        es[0] = 64'hFFFF_FFFF_FFFF_FFFE; ec[0] = 1'b0; eo[0] = 1'b0;
        ta[1] = 64'd7;                   tb[1] = 64'd5;
        es[1] = 64'd2;                   ec[1] = 1'b1; eo[1] = 1'b0;
        ta[2] = 64'd0;                   tb[2] = 64'd0;
        es[2] = 64'd0;                   ec[2] = 1'b1; eo[2] = 1'b0;
        ta[3] = 64'h8000_0000_0000_0000; tb[3] = 64'd1;
        es[3] = 64'h7FFF_FFFF_FFFF_FFFF; ec[3] = 1'b1; eo[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // cin is driven low on purpose: subtract mode must force it to 1
            drive(ta[i], tb[i], 1'b0, 1'b1);
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_sum !== es[i]) begin errors++; $display("FAIL sub_sum[%0d]: got %h expected %h", i, out_sum, es[i]); end
            checks++; if (out_cout !== ec[i]) begin errors++; $display("FAIL sub_cout[%0d]: got %b expected %b", i, out_cout, ec[i]); end
`ifdef CSLA_PIPE_OVF_EN
            checks++; if (out_ovf !== eo[i]) begin errors++; $display("FAIL sub_ovf[%0d]: got %b expected %b", i, out_ovf, eo[i]); end
`else
            if (eo[i] === 1'bx) $display("note: unexpected table entry");
`endif
        end
        in_sub = 1'b0;
    endtask

    task automatic test_back_to_back();
        localparam int N = 24;
        logic [W-1:0] ta [N];
        logic [W-1:0] tb [N];
        logic         tc [N];
        logic         tsb [N];
        logic [W:0]   ex [N];
        for (int i = 0; i < N; i++) begin
            ta[i]  = 64'h9E37_79B9_7F4A_7C15 * 64'(i + 1);
            tb[i]  = (i % 5 == 4) ? ~ta[i] : (64'hFFFF_FFFF_0000_0001 ^ (ta[i] << 3));
            tc[i]  = i[0];
            tsb[i] = i[1];
            ex[i]  = model(ta[i], tb[i], tc[i], tsb[i]);
        end
        for (int c = 0; c < N + 3; c++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", c, in_ready); end
            if (c >= 2 && c < N + 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", c - 2, out_valid); end
                checks++; if (out_sum !== ex[c-2][W-1:0]) begin errors++; $display("FAIL b2b_sum[%0d]: got %h expected %h", c - 2, out_sum, ex[c-2][W-1:0]); end
                checks++; if (out_cout !== ex[c-2][W]) begin errors++; $display("FAIL b2b_cout[%0d]: got %b expected %b", c - 2, out_cout, ex[c-2][W]); end
            end else if (c == N + 2) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble: got %b expected 0", out_valid); end
            end
            if (c < N) begin
                in_valid = 1'b1;
                in_a     = ta[c];
                in_b     = tb[c];
                in_cin   = tc[c];
                in_sub   = tsb[c];
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_sub = 1'b0;
    endtask

    task automatic test_backpressure();
        localparam int NB = 4;
        logic [W-1:0] ta [NB];
        logic [W-1:0] tb [NB];
        logic [W:0]   ex [NB];
        int j = 0;
        int k = 0;
        ta[0] = 64'd10;                  tb[0] = 64'd20;
        ta[1] = 64'hFFFF_FFFF_FFFF_FFF0; tb[1] = 64'h20;
        ta[2] = 64'h0000_0001_0000_0000; tb[2] = 64'h0000_0002_0000_0000;
        ta[3] = 64'h7FFF_FFFF_FFFF_FFFF; tb[3] = 64'h7FFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < NB; i++) ex[i] = model(ta[i], tb[i], 1'b0, 1'b0);
        in_cin = 1'b0;
        in_sub = 1'b0;
        for (int c = 0; c < 40 && k < NB; c++) begin
            out_ready = !(c >= 2 && c < 7);
            if (j < NB) begin
                in_valid = 1'b1;
                in_a     = ta[j];
                in_b     = tb[j];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", c, out_valid); end
                checks++; if (out_sum !== ex[k][W-1:0]) begin errors++; $display("FAIL bp_hold_sum[%0d]: got %h expected %h", c, out_sum, ex[k][W-1:0]); end
            end
            if (out_valid && out_ready) begin
                checks++; if (out_sum !== ex[k][W-1:0]) begin errors++; $display("FAIL bp_sum[%0d]: got %h expected %h", k, out_sum, ex[k][W-1:0]); end
                checks++; if (out_cout !== ex[k][W]) begin errors++; $display("FAIL bp_cout[%0d]: got %b expected %b", k, out_cout, ex[k][W]); end
                k++;
            end
            if (in_valid && in_ready) j++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (k !== NB) begin errors++; $display("FAIL bp_count: got %0d results expected %0d", k, NB); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_midop_reset();
        in_valid = 1'b1;
        in_a = 64'd1; in_b = 64'd2; in_cin = 1'b0; in_sub = 1'b0;
        tick();
        in_a = 64'd3; in_b = 64'd3;
        tick();
        in_valid = 1'b0;
        checks++; if (out_sum !== 64'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight: valid %b sum %h expected 1 / 3", out_valid, out_sum); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
        checks++; if (out_sum !== 64'd0) begin errors++; $display("FAIL mid_async_sum: got %h expected 0", out_sum); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_output[%0d]: got %b expected 0", c, out_valid); end
        end
        drive(64'd3, 64'd4, 1'b0, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_next_valid: got %b expected 1", out_valid); end
        checks++; if (out_sum !== 64'd7) begin errors++; $display("FAIL mid_next_sum: got %h expected 7", out_sum); end
`ifdef CSLA_PIPE_OVF_EN
        drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        tick();
        checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL mid_ovf: got %b expected 1", out_ovf); end
        checks++; if (out_sum !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL mid_ovf_sum: got %h expected 8000000000000000", out_sum); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL mid_ovf_cout: got %b expected 0", out_cout); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_midop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
